data_memory_logged: RTL and testbench

- Parametrised successor to the single-port CPU_NN data memory.
- Word-addressed synchronous RAM with byte-enable stores and a one-cycle registered load response on a valid/ready request port.
- Optional post-reset clear sweep.
- Hardware store-log FIFO (address, data, byte-enable) drained by the testbench or a host over a valid/ready port; replaces file-writing on every store.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/data_memory_logged_store_log_fifo.sv | 77 +++++++
 rtl/data_memory_logged.sv | 181 ++++++++++++++++++
 tb/tb_data_memory_logged.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the logged data memory.
// Holds the FSM state encoding, default bus widths, the default-width log
// entry layout and small width helpers so that every instance derives its
// byte-enable and counter widths the same way.
package dmem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_LOG_DEPTH  = 16;

  localparam int unsigned BE_WIDTH  = DEF_DATA_WIDTH / 8;
  localparam int unsigned LOG_CNT_W = $clog2(DEF_LOG_DEPTH + 1);

  // Sweep-then-serve controller states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

  // Store-log entry at default widths; instances build the same layout
  // locally from their own parameters.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]       be;
  } log_entry_t;

  // One enable bit per byte lane
  function automatic int unsigned be_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Counter wide enough to hold 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_memory_logged_store_log_fifo.sv
// Synchronous FIFO used as the store log.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_wdata   append an entry (dropped when full and not popping)
//   i_pop             remove head (ignored when empty)
//   o_rdata           head entry, stable until popped
//   o_full, o_empty   occupancy flags
//   o_count           entries held, 0..DEPTH
//   o_overflow        sticky: a push was dropped since reset
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module store_log_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  // A same-cycle pop frees the slot the push needs
  assign w_push  = i_push & (~w_full | w_pop);

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && !w_push) r_overflow <= 1'b1;
    end
  end

  // Entry storage
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata    = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/data_memory_logged.sv
// Word-addressed synchronous data memory with byte-enable stores, a
// one-cycle registered load response, an optional post-reset clear sweep
// and a hardware log of every accepted store.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in RUN)
//   req_write, req_addr,        1 = store, 0 = load; word address;
//   req_wdata, req_be           store data and per-byte enables
//   rsp_valid, rsp_rdata,       one-cycle load response; rsp_err flags an
//   rsp_err                     address beyond the implemented depth
//   log_valid/log_ready         store-log head handshake
//   log_addr, log_data, log_be  head entry fields
//   log_count, log_overflow     log occupancy and sticky drop flag
//   busy                        clear sweep in progress
module data_memory_logged
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DEPTH          = 2**ADDR_WIDTH,
  parameter int unsigned LOG_DEPTH      = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [DATA_WIDTH/8-1:0]        req_be,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           log_valid,
  input  logic                           log_ready,
  output logic [ADDR_WIDTH-1:0]          log_addr,
  output logic [DATA_WIDTH-1:0]          log_data,
  output logic [DATA_WIDTH/8-1:0]        log_be,
  output logic [$clog2(LOG_DEPTH+1)-1:0] log_count,
  output logic                           log_overflow,
  output logic                           busy
);

  localparam int unsigned BEW     = be_width(DATA_WIDTH);
  localparam int unsigned CNT_W   = cnt_width(LOG_DEPTH);
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH + BEW;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BEW-1:0]        be;
  } entry_t;

  dmem_state_e          r_state;
  dmem_state_e          w_state_nxt;
  logic [IDX_W-1:0]     r_clr_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic             w_busy;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_store;
  logic             w_load;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_clr_last;

  entry_t           w_push_entry;
  entry_t           w_head_entry;
  logic [ENTRY_W-1:0] w_head_bits;
  logic             w_log_empty;
  logic             w_log_full_unused;
  logic [CNT_W-1:0] w_log_count;
  logic             w_log_overflow;

  assign w_accept   = req_valid & w_req_ready;
  assign w_store    = w_accept & req_write;
  assign w_load     = w_accept & ~req_write;
  // Widened compare so any ADDR_WIDTH/DEPTH pairing is exact
  assign w_in_range = (64'(req_addr) < 64'(DEPTH));
  assign w_idx      = IDX_W'(req_addr);
  assign w_clr_last = (r_clr_addr == IDX_W'(DEPTH - 1));

  // State register and sweep address
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + IDX_W'(1);
    end
  end

  // Next-state: leave CLEAR once the last word has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // State decode
  always_comb begin
    w_busy      = 1'b0;
    w_req_ready = 1'b0;
    case (r_state)
      ST_CLEAR: w_busy      = 1'b1;
      ST_RUN:   w_req_ready = 1'b1;
      default:  w_req_ready = 1'b0;
    endcase
  end

  // RAM: sweep writes zero; stores merge only enabled byte lanes
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_store && w_in_range) begin
        for (int i = 0; i < BEW; i++) begin
          if (req_be[i]) r_mem[w_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Load response; data holds between responses
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_load;
      r_rsp_err   <= w_load & ~w_in_range;
      if (w_load) r_rsp_rdata <= w_in_range ? r_mem[w_idx] : '0;
    end
  end

  // Every accepted store is logged with its raw data and enables
  assign w_push_entry = '{addr: req_addr, data: req_wdata, be: req_be};

  store_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_push     (w_store),
    .i_wdata    (w_push_entry),
    .i_pop      (log_ready),
    .o_rdata    (w_head_bits),
    .o_full     (w_log_full_unused),
    .o_empty    (w_log_empty),
    .o_count    (w_log_count),
    .o_overflow (w_log_overflow)
  );

  assign w_head_entry = entry_t'(w_head_bits);

  assign req_ready    = w_req_ready;
  assign busy         = w_busy;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign log_valid    = ~w_log_empty;
  assign log_addr     = w_head_entry.addr;
  assign log_data     = w_head_entry.data;
  assign log_be       = w_head_entry.be;
  assign log_count    = w_log_count;
  assign log_overflow = w_log_overflow;

endmodule

// File: tb/tb_data_memory_logged.sv
// Self-checking bench for data_memory_logged (DEPTH=64, LOG_DEPTH=4).
module tb_data_memory_logged;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LOGD  = 4;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic        rsp_err;
  logic        log_valid;
  logic        log_ready;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_data;
  logic [3:0]  log_be;
  logic [2:0]  log_count;
  logic        log_overflow;
  logic        busy;

  data_memory_logged #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEPTH          (DEPTH),
    .LOG_DEPTH      (LOGD),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_be       (log_be),
    .log_count    (log_count),
    .log_overflow (log_overflow),
    .busy         (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain word array, FIFO queue, sticky flag
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mmem [DEPTH];
  bit          movf;
  logic [31:0] mlast;

  int n_chk;
  int n_fail;

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          lr;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    q.delete();
    movf  = 1'b0;
    mlast = '0;
  endtask

  // Hold reset for some edges, check reset values, then release
  task automatic do_reset(input int cycles);
    RST = 1'b1;
    req_valid = 1'b0;
    log_ready = 1'b0;
    repeat (cycles) @(posedge CLK);
    #1;
    model_reset();
    chk("rst_busy",      64'(busy), 64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err), 64'd0);
    chk("rst_log_valid", 64'(log_valid), 64'd0);
    chk("rst_log_count", 64'(log_count), 64'd0);
    chk("rst_log_ovf",   64'(log_overflow), 64'd0);
    RST = 1'b0;
  endtask

  // Count cycles of busy after reset release (bounded)
  task automatic wait_sweep();
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 200) begin
      if (req_ready !== 1'b0) bad++;
      n++;
      @(posedge CLK);
      #1;
    end
    chk("sweep_len",       64'(n), 64'(DEPTH));
    chk("sweep_ready_low", 64'(bad), 64'd0);
    chk("sweep_done_busy", 64'(busy), 64'd0);
    chk("sweep_done_rdy",  64'(req_ready), 64'd1);
  endtask

  // One RUN-mode cycle: drive, advance the model, compare after the edge
  task automatic step(input bit v, input bit w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] be, input bit lr);
    ent_t e;
    bit   exp_v;
    bit   exp_err;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    log_ready = lr;
    exp_v   = v && !w;
    exp_err = exp_v && (a >= 8'(DEPTH));
    if (exp_v) mlast = (a >= 8'(DEPTH)) ? 32'h0 : mmem[a[5:0]];
    if (lr && q.size() > 0) q.delete(0);
    if (v && w) begin
      e.a = a;
      e.d = d;
      e.be = be;
      if (q.size() < LOGD) q.push_back(e);
      else movf = 1'b1;
      if (a < 8'(DEPTH)) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mmem[a[5:0]][i*8 +: 8] = d[i*8 +: 8];
      end
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    log_ready = 1'b0;
    chk("req_ready", 64'(req_ready), 64'd1);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(mlast));
    if (exp_v) chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("log_count", 64'(log_count), 64'(q.size()));
    chk("log_valid", 64'(log_valid), 64'(q.size() > 0));
    chk("log_ovf",   64'(log_overflow), 64'(movf));
    if (q.size() > 0) begin
      chk("log_addr", 64'(log_addr), 64'(q[0].a));
      chk("log_data", 64'(log_data), 64'(q[0].d));
      chk("log_be",   64'(log_be), 64'(q[0].be));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && log_valid === 1'b1; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
    chk("drain_empty", 64'(log_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    RST = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_be = '0;
    log_ready = 1'b0;

    //       wr    addr   wdata          be    lr    exp_rd         err   cnt
    vt[0] = '{1'b1, 8'd3,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0,         1'b0, 1};
    vt[1] = '{1'b1, 8'd3,  32'h11223344, 4'h5, 1'b0, 32'h0,         1'b0, 2};
    vt[2] = '{1'b0, 8'd3,  32'h0,        4'h0, 1'b1, 32'hDE22BE44,  1'b0, 1};
    vt[3] = '{1'b0, 8'd5,  32'h0,        4'h0, 1'b1, 32'h0,         1'b0, 0};
    vt[4] = '{1'b0, 8'd70, 32'h0,        4'h0, 1'b1, 32'h0,         1'b1, 0};
    vt[5] = '{1'b1, 8'd70, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0,         1'b0, 1};
    vt[6] = '{1'b1, 8'd7,  32'hAABBCCDD, 4'h0, 1'b0, 32'h0,         1'b0, 2};
    vt[7] = '{1'b0, 8'd7,  32'h0,        4'h0, 1'b0, 32'h0,         1'b0, 2};
    vt[8] = '{1'b1, 8'd7,  32'hAABBCCDD, 4'hF, 1'b0, 32'h0,         1'b0, 3};
    vt[9] = '{1'b0, 8'd7,  32'h0,        4'h0, 1'b0, 32'hAABBCCDD,  1'b0, 3};

    do_reset(3);
    wait_sweep();

    // Directed table
    foreach (vt[i]) begin
      step(1'b1, vt[i].wr, vt[i].a, vt[i].d, vt[i].be, vt[i].lr);
      if (!vt[i].wr) begin
        chk("tbl_rdata", 64'(rsp_rdata), 64'(vt[i].exp_rd));
        chk("tbl_err",   64'(rsp_err), 64'(vt[i].exp_err));
      end
      chk("tbl_count", 64'(log_count), 64'(vt[i].exp_cnt));
    end
    // Out-of-range store left word 70's neighbourhood alone: addr 6 still 0
    step(1'b1, 1'b0, 8'd6, 32'd0, 4'd0, 1'b0);
    chk("oor_store_no_alias", 64'(rsp_rdata), 64'd0);
    drain();

    // Full log with a same-cycle pop: push lands at the tail, no overflow
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(20 + i), 32'h100 + 32'(i), 4'hF, 1'b0);
    step(1'b1, 1'b1, 8'd24, 32'h104, 4'hF, 1'b1);
    chk("fullpop_count", 64'(log_count), 64'd4);
    chk("fullpop_ovf",   64'(log_overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_head", 64'(log_addr), 64'(21 + i));
      step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
    end
    chk("fullpop_empty", 64'(log_valid), 64'd0);

    // Overflow: six stores into a four-entry log with no draining
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 8'(10 + i), 32'h200 + 32'(i), 4'hF, 1'b0);
    chk("ovf_count", 64'(log_count), 64'd4);
    chk("ovf_flag",  64'(log_overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_head_addr", 64'(log_addr), 64'(10 + i));
      chk("ovf_head_data", 64'(log_data), 64'(32'h200 + 32'(i)));
      step(1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
    end
    chk("ovf_drained",  64'(log_valid), 64'd0);
    chk("ovf_sticky",   64'(log_overflow), 64'd1);
    // Dropped stores still wrote memory
    step(1'b1, 1'b0, 8'd15, 32'd0, 4'd0, 1'b0);
    chk("ovf_mem_written", 64'(rsp_rdata), 64'h205);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, ($urandom % 2) == 1, 8'($urandom_range(0, 79)),
           $urandom, 4'($urandom), ($urandom % 3) == 0);
    end

    // Reset in the middle of the sweep restarts it from address 0
    do_reset(2);
    repeat (20) @(posedge CLK);
    #1;
    chk("midsweep_busy", 64'(busy), 64'd1);
    do_reset(1);
    wait_sweep();
    chk("midsweep_log_empty", 64'(log_count), 64'd0);
    step(1'b1, 1'b0, 8'd3, 32'd0, 4'd0, 1'b0);
    chk("cleared_addr3", 64'(rsp_rdata), 64'd0);
    step(1'b1, 1'b0, 8'd63, 32'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 8'd15, 32'd0, 4'd0, 1'b0);
    chk("cleared_addr15", 64'(rsp_rdata), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
